// File: rtl/l15_mem_responder_pkg.sv
// rtl/l15_mem_responder_pkg.sv - shared L1.5 widths, request/return codes and responder state encoding
//
// Purpose : common definitions for the L1.5 memory responder and its RAM.
// Contents: PHY_ADDR_WIDTH, L15_AMO_OP_WIDTH, rqtype and returntype codes,
//           responder FSM state type, request decode and store byte-enable helpers.
package l15_mem_responder_pkg;

    localparam int PHY_ADDR_WIDTH   = 40;
    localparam int L15_AMO_OP_WIDTH = 4;

    localparam logic [4:0] LOAD_RQ  = 5'b00000;
    localparam logic [4:0] IMISS_RQ = 5'b10000;
    localparam logic [4:0] STORE_RQ = 5'b00001;

    localparam logic [3:0] LOAD_RET  = 4'b0000;
    localparam logic [3:0] IFILL_RET = 4'b0001;
    localparam logic [3:0] ST_ACK    = 4'b0100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        DELAY  = 2'd2,
        RESP   = 2'd3
    } state_t;

    // A request is serviced only for the three known types with size 0..3;
    // anything else is answered as a zero-data store ack.
    function automatic logic req_ok(input logic [4:0] rqtype, input logic [2:0] size);
        return ((rqtype == LOAD_RQ) || (rqtype == IMISS_RQ) || (rqtype == STORE_RQ)) && !size[2];
    endfunction

    function automatic logic [3:0] ret_code(input logic [4:0] rqtype, input logic [2:0] size);
        if (!req_ok(rqtype, size))  return ST_ACK;
        else if (rqtype == LOAD_RQ) return LOAD_RET;
        else if (rqtype == IMISS_RQ) return IFILL_RET;
        else                         return ST_ACK;
    endfunction

    // Byte offset k lives in bits [63-8k:56-8k], i.e. byte-enable bit 7-k.
    // The access is aligned down to its own size before lanes are chosen.
    function automatic logic [7:0] store_be(input logic [1:0] size, input logic [2:0] offset);
        logic [3:0] nbytes;
        logic [2:0] first;
        logic [7:0] be;
        nbytes = 4'd1 << size;
        first  = offset & ~3'(nbytes - 4'd1);
        be     = '0;
        for (int k = 0; k < 8; k++) begin
            if ((k >= int'(first)) && (k < int'(first) + int'(nbytes))) begin
                be[7-k] = 1'b1;
            end
        end
        return be;
    endfunction

endpackage

// File: rtl/l15_mem_responder_ram.sv
// rtl/l15_mem_responder_ram.sv - MEM_WORDS x 64 backing store, byte-enable write, registered two-word read
//
// Purpose : backing memory for the L1.5 responder. The single read port returns
//           the addressed word and its successor (wrapping) so a load can fill
//           both response beats from one registered access.
// Ports   : clk                         - clock
//           wr_en, wr_addr, wr_be, wr_data - write port, wr_be[i] covers bits [8i+7:8i]
//           rd_en, rd_addr              - read request, captured on the rising edge
//           rd_data_0, rd_data_1        - mem[rd_addr], mem[rd_addr+1]; held until next rd_en
module l15_mem_responder_ram #(
    parameter int WORDS = 256
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(WORDS)-1:0] wr_addr,
    input  logic [7:0]               wr_be,
    input  logic [63:0]              wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(WORDS)-1:0] rd_addr,
    output logic [63:0]              rd_data_0,
    output logic [63:0]              rd_data_1
);

    localparam int AW = $clog2(WORDS);

    // Zeroed once at time zero; reset never touches the contents.
    logic [63:0]   mem [WORDS] = '{default: '0};
    logic [AW-1:0] rd_addr_next;

    // Natural AW-bit wrap gives (idx+1) mod WORDS.
    assign rd_addr_next = rd_addr + AW'(1);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_data_0 <= mem[rd_addr];
            rd_data_1 <= mem[rd_addr_next];
        end
    end

endmodule

// File: rtl/l15_mem_responder.sv
// rtl/l15_mem_responder.sv - single-outstanding L1.5 memory responder with fixed response latency
//
// Purpose : accepts one transducer request at a time, performs the store or
//           load against a local RAM and returns a response RESP_LATENCY
//           cycles after the accept cycle.
// Ports   : clk, reset                      - clock, synchronous active-high reset
//           transducer_l15_*                - request (val, rqtype, size, address, data, nc, amo_op)
//           l15_transducer_ack/header_ack   - one-cycle accept strobe
//           l15_transducer_val/returntype/data_0/data_1 - response, held until req_ack
//           transducer_l15_req_ack          - response consumed
//           err                             - one-cycle pulse for an unsupported request
module l15_mem_responder
    import l15_mem_responder_pkg::*;
#(
    parameter int MEM_WORDS    = 256,
    parameter int RESP_LATENCY = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        transducer_l15_val,
    input  logic [4:0]                  transducer_l15_rqtype,
    input  logic [2:0]                  transducer_l15_size,
    input  logic [PHY_ADDR_WIDTH-1:0]   transducer_l15_address,
    input  logic [63:0]                 transducer_l15_data,
    input  logic                        transducer_l15_nc,
    input  logic [L15_AMO_OP_WIDTH-1:0] transducer_l15_amo_op,
    output logic                        l15_transducer_ack,
    output logic                        l15_transducer_header_ack,
    output logic                        l15_transducer_val,
    output logic [3:0]                  l15_transducer_returntype,
    output logic [63:0]                 l15_transducer_data_0,
    output logic [63:0]                 l15_transducer_data_1,
    input  logic                        transducer_l15_req_ack,
    output logic                        err
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CNT_W = (RESP_LATENCY > 1) ? $clog2(RESP_LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(RESP_LATENCY - 1);

    state_t           state;
    logic [4:0]       rqtype_q;
    logic [2:0]       size_q;
    logic [IDX_W+2:0] addr_q;
    logic [63:0]      data_q;
    logic [CNT_W-1:0] lat_cnt;

    logic             ok_q;
    logic             ram_wr_en;
    logic             ram_rd_en;
    logic [63:0]      ram_q0;
    logic [63:0]      ram_q1;
    logic             resp_has_data;
    logic             unused_inputs;

    assign ok_q      = req_ok(rqtype_q, size_q);
    assign ram_wr_en = (state == ACCEPT) && ok_q && (rqtype_q == STORE_RQ);
    assign ram_rd_en = (state == ACCEPT) && ok_q && (rqtype_q != STORE_RQ);

    // Write data is taken from the same lanes it lands in, so the full
    // 64-bit request word goes straight to the RAM under the byte enables.
    l15_mem_responder_ram #(
        .WORDS (MEM_WORDS)
    ) u_ram (
        .clk       (clk),
        .wr_en     (ram_wr_en),
        .wr_addr   (addr_q[IDX_W+2:3]),
        .wr_be     (store_be(size_q[1:0], addr_q[2:0])),
        .wr_data   (data_q),
        .rd_en     (ram_rd_en),
        .rd_addr   (addr_q[IDX_W+2:3]),
        .rd_data_0 (ram_q0),
        .rd_data_1 (ram_q1)
    );

    // The RAM read register only reloads in ACCEPT, so it is stable for the
    // whole RESP window; gating keeps data at zero outside load responses.
    assign resp_has_data = l15_transducer_val &&
                           ((l15_transducer_returntype == LOAD_RET) ||
                            (l15_transducer_returntype == IFILL_RET));
    assign l15_transducer_data_0 = resp_has_data ? ram_q0 : '0;
    assign l15_transducer_data_1 = resp_has_data ? ram_q1 : '0;

    // Upper address bits alias; nc and amo_op do not change behaviour.
    assign unused_inputs = ^{transducer_l15_nc, transducer_l15_amo_op,
                             transducer_l15_address[PHY_ADDR_WIDTH-1:IDX_W+3]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state                     <= IDLE;
            rqtype_q                  <= '0;
            size_q                    <= '0;
            addr_q                    <= '0;
            data_q                    <= '0;
            lat_cnt                   <= '0;
            l15_transducer_ack        <= 1'b0;
            l15_transducer_header_ack <= 1'b0;
            l15_transducer_val        <= 1'b0;
            l15_transducer_returntype <= '0;
            err                       <= 1'b0;
        end else begin
            l15_transducer_ack        <= 1'b0;
            l15_transducer_header_ack <= 1'b0;
            err                       <= 1'b0;
            case (state)
                IDLE: begin
                    if (transducer_l15_val) begin
                        rqtype_q                  <= transducer_l15_rqtype;
                        size_q                    <= transducer_l15_size;
                        addr_q                    <= transducer_l15_address[IDX_W+2:0];
                        data_q                    <= transducer_l15_data;
                        l15_transducer_ack        <= 1'b1;
                        l15_transducer_header_ack <= 1'b1;
                        err                       <= !req_ok(transducer_l15_rqtype, transducer_l15_size);
                        state                     <= ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (RESP_LATENCY == 1) begin
                        l15_transducer_val        <= 1'b1;
                        l15_transducer_returntype <= ret_code(rqtype_q, size_q);
                        state                     <= RESP;
                    end else begin
                        lat_cnt <= CNT_W'(1);
                        state   <= DELAY;
                    end
                end
                DELAY: begin
                    if (lat_cnt == LAT_LAST) begin
                        lat_cnt                   <= '0;
                        l15_transducer_val        <= 1'b1;
                        l15_transducer_returntype <= ret_code(rqtype_q, size_q);
                        state                     <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (transducer_l15_req_ack) begin
                        l15_transducer_val <= 1'b0;
                        state              <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l15_mem_responder.sv
// tb/tb_l15_mem_responder.sv - directed vector bench for l15_mem_responder
module tb_l15_mem_responder;
    import l15_mem_responder_pkg::*;

    localparam int LAT = 3;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        transducer_l15_val;
    logic [4:0]                  transducer_l15_rqtype;
    logic [2:0]                  transducer_l15_size;
    logic [PHY_ADDR_WIDTH-1:0]   transducer_l15_address;
    logic [63:0]                 transducer_l15_data;
    logic                        transducer_l15_nc;
    logic [L15_AMO_OP_WIDTH-1:0] transducer_l15_amo_op;
    logic                        l15_transducer_ack;
    logic                        l15_transducer_header_ack;
    logic                        l15_transducer_val;
    logic [3:0]                  l15_transducer_returntype;
    logic [63:0]                 l15_transducer_data_0;
    logic [63:0]                 l15_transducer_data_1;
    logic                        transducer_l15_req_ack;
    logic                        err;

    always #5 clk = ~clk;

    l15_mem_responder #(
        .MEM_WORDS    (256),
        .RESP_LATENCY (LAT)
    ) dut (
        .clk                       (clk),
        .reset                     (reset),
        .transducer_l15_val        (transducer_l15_val),
        .transducer_l15_rqtype     (transducer_l15_rqtype),
        .transducer_l15_size       (transducer_l15_size),
        .transducer_l15_address    (transducer_l15_address),
        .transducer_l15_data       (transducer_l15_data),
        .transducer_l15_nc         (transducer_l15_nc),
        .transducer_l15_amo_op     (transducer_l15_amo_op),
        .l15_transducer_ack        (l15_transducer_ack),
        .l15_transducer_header_ack (l15_transducer_header_ack),
        .l15_transducer_val        (l15_transducer_val),
        .l15_transducer_returntype (l15_transducer_returntype),
        .l15_transducer_data_0     (l15_transducer_data_0),
        .l15_transducer_data_1     (l15_transducer_data_1),
        .transducer_l15_req_ack    (transducer_l15_req_ack),
        .err                       (err)
    );

    typedef struct packed {
        logic [4:0]                rqtype;
        logic [2:0]                size;
        logic [PHY_ADDR_WIDTH-1:0] addr;
        logic [63:0]               data;
        logic [3:0]                exp_rt;
        logic [63:0]               exp_d0;
        logic [63:0]               exp_d1;
        logic                      exp_err;
    } vec_t;

    vec_t vecs [15];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Issues one request from a negedge and runs it to completion; returns at
    // the negedge after the req_ack cycle. keep_val leaves the request asserted.
    task automatic run_txn(input string tag, input vec_t v, input int hold, input bit keep_val);
        int          cycles, acks, hacks, errs, acc_at, val_at;
        bit          seen, stable;
        logic [3:0]  rt0;
        logic [63:0] d0, d1;
        transducer_l15_val     = 1'b1;
        transducer_l15_rqtype  = v.rqtype;
        transducer_l15_size    = v.size;
        transducer_l15_address = v.addr;
        transducer_l15_data    = v.data;
        transducer_l15_amo_op  = 4'($urandom_range(0, 15));
        cycles = 0; acks = 0; hacks = 0; errs = 0; acc_at = -1; val_at = -1; seen = 0;
        while (!seen && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (l15_transducer_ack) begin
                acks++;
                if (acc_at < 0) acc_at = cycles;
                if (!keep_val) transducer_l15_val = 1'b0;
            end
            if (l15_transducer_header_ack) hacks++;
            if (err) errs++;
            if (l15_transducer_val) begin
                seen   = 1;
                val_at = cycles;
            end
        end
        chk({tag, "_resp_seen"}, 64'(seen), 64'd1);
        rt0 = l15_transducer_returntype;
        d0  = l15_transducer_data_0;
        d1  = l15_transducer_data_1;
        stable = 1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (l15_transducer_ack) acks++;
            if (l15_transducer_header_ack) hacks++;
            if (err) errs++;
            if (!l15_transducer_val || l15_transducer_returntype !== rt0 ||
                l15_transducer_data_0 !== d0 || l15_transducer_data_1 !== d1) stable = 0;
        end
        transducer_l15_req_ack = 1'b1;
        @(negedge clk);
        transducer_l15_req_ack = 1'b0;
        if (l15_transducer_ack) acks++;
        chk({tag, "_val_drop"}, 64'(l15_transducer_val), 64'd0);
        chk({tag, "_ack_cnt"}, 64'(acks), 64'd1);
        chk({tag, "_hdr_ack_cnt"}, 64'(hacks), 64'd1);
        chk({tag, "_err_cnt"}, 64'(errs), 64'(v.exp_err));
        chk({tag, "_latency"}, 64'(val_at - acc_at), 64'(LAT));
        chk({tag, "_stable"}, 64'(stable), 64'd1);
        chk({tag, "_rt"}, 64'(rt0), 64'(v.exp_rt));
        chk({tag, "_d0"}, d0, v.exp_d0);
        chk({tag, "_d1"}, d1, v.exp_d1);
    endtask

    initial begin
        int   cycles;
        int   vseen;
        vec_t v;

        reset                  = 1'b1;
        transducer_l15_val     = 1'b0;
        transducer_l15_rqtype  = '0;
        transducer_l15_size    = '0;
        transducer_l15_address = '0;
        transducer_l15_data    = '0;
        transducer_l15_nc      = 1'b0;
        transducer_l15_amo_op  = '0;
        transducer_l15_req_ack = 1'b0;

        //             rqtype    size  addr                data                   rt         d0                     d1                     err
        vecs[0]  = '{STORE_RQ, 3'd3, 40'h40,           64'h0123456789ABCDEF, ST_ACK,    64'h0,                 64'h0,                 1'b0};
        vecs[1]  = '{LOAD_RQ,  3'd3, 40'h40,           64'h0,                LOAD_RET,  64'h0123456789ABCDEF, 64'h0,                 1'b0};
        vecs[2]  = '{STORE_RQ, 3'd2, 40'h44,           64'hFFFFFFFFDEADBEEF, ST_ACK,    64'h0,                 64'h0,                 1'b0};
        vecs[3]  = '{LOAD_RQ,  3'd3, 40'h40,           64'h0,                LOAD_RET,  64'h01234567DEADBEEF, 64'h0,                 1'b0};
        vecs[4]  = '{LOAD_RQ,  3'd3, 40'h38,           64'h0,                LOAD_RET,  64'h0,                 64'h01234567DEADBEEF, 1'b0};
        vecs[5]  = '{STORE_RQ, 3'd0, 40'h4B,           64'h1122334455667788, ST_ACK,    64'h0,                 64'h0,                 1'b0};
        vecs[6]  = '{STORE_RQ, 3'd1, 40'h4F,           64'hAAAABBBBCCCCDDEE, ST_ACK,    64'h0,                 64'h0,                 1'b0};
        vecs[7]  = '{LOAD_RQ,  3'd3, 40'h40,           64'h0,                LOAD_RET,  64'h01234567DEADBEEF, 64'h000000440000DDEE, 1'b0};
        vecs[8]  = '{STORE_RQ, 3'd3, 40'h10_0000_07F8, 64'hCAFEF00D12345678, ST_ACK,    64'h0,                 64'h0,                 1'b0};
        vecs[9]  = '{STORE_RQ, 3'd3, 40'h0,            64'h5555AAAA5555AAAA, ST_ACK,    64'h0,                 64'h0,                 1'b0};
        vecs[10] = '{IMISS_RQ, 3'd3, 40'h7F8,          64'h0,                IFILL_RET, 64'hCAFEF00D12345678, 64'h5555AAAA5555AAAA, 1'b0};
        vecs[11] = '{5'b00110, 3'd3, 40'h40,           64'hFFFFFFFFFFFFFFFF, ST_ACK,    64'h0,                 64'h0,                 1'b1};
        vecs[12] = '{STORE_RQ, 3'd4, 40'h40,           64'hFFFFFFFFFFFFFFFF, ST_ACK,    64'h0,                 64'h0,                 1'b1};
        vecs[13] = '{LOAD_RQ,  3'd3, 40'h40,           64'h0,                LOAD_RET,  64'h01234567DEADBEEF, 64'h000000440000DDEE, 1'b0};
        vecs[14] = '{LOAD_RQ,  3'd3, 40'h47,           64'h0,                LOAD_RET,  64'h01234567DEADBEEF, 64'h000000440000DDEE, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_ack", 64'(l15_transducer_ack), 64'd0);
        chk("rst_hdr_ack", 64'(l15_transducer_header_ack), 64'd0);
        chk("rst_val", 64'(l15_transducer_val), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_rt", 64'(l15_transducer_returntype), 64'd0);
        chk("rst_d0", l15_transducer_data_0, 64'd0);
        chk("rst_d1", l15_transducer_data_1, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            transducer_l15_nc = 1'(i % 2);
            run_txn($sformatf("v%0d", i), vecs[i], (i == 3) ? 5 : (i % 3), 1'b0);
        end

        // Request held high throughout: ignored while busy, re-accepted
        // straight after the req_ack cycle.
        run_txn("keepval", vecs[13], 2, 1'b1);
        chk("reaccept_gap_ack", 64'(l15_transducer_ack), 64'd0);
        @(negedge clk);
        chk("reaccept_ack", 64'(l15_transducer_ack), 64'd1);
        transducer_l15_val = 1'b0;
        cycles = 0;
        while (!l15_transducer_val && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        chk("reaccept_resp_seen", 64'(l15_transducer_val), 64'd1);
        chk("reaccept_d0", l15_transducer_data_0, 64'h01234567DEADBEEF);
        transducer_l15_req_ack = 1'b1;
        @(negedge clk);
        transducer_l15_req_ack = 1'b0;
        chk("reaccept_val_drop", 64'(l15_transducer_val), 64'd0);

        // Reset during DELAY of a store: no response, store already written.
        transducer_l15_val     = 1'b1;
        transducer_l15_rqtype  = STORE_RQ;
        transducer_l15_size    = 3'd3;
        transducer_l15_address = 40'h80;
        transducer_l15_data    = 64'h0F1E2D3C4B5A6978;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!l15_transducer_ack && cycles < 20);
        chk("rstseq_ack", 64'(l15_transducer_ack), 64'd1);
        transducer_l15_val = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstseq_val_in_reset", 64'(l15_transducer_val), 64'd0);
        vseen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (l15_transducer_val) vseen++;
        end
        chk("rstseq_no_resp", 64'(vseen), 64'd0);
        v = '{LOAD_RQ, 3'd3, 40'h80, 64'h0, LOAD_RET, 64'h0F1E2D3C4B5A6978, 64'h0, 1'b0};
        run_txn("rstseq_load", v, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
